// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32 x 32-bit MIPS register file, two combinational read
// ports (rs, rt) and one synchronous write port. Register 0 is hardwired to
// zero and has no storage. BYPASS selects write-through on same-cycle reads.

// One storage register; synchronous clear wins over a same-edge write.
module reg_file_2r1w_entry #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // clear on reset, otherwise load when this register is the write target
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// One combinational read port: select stored word, optionally override with
// in-flight write data, and force index 0 to read zero.
module reg_file_2r1w_rport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32
) (
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] store,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic                             byp_hit,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [DATA_WIDTH-1:0]            data
);

  // index 0 beats bypass so a write to r0 can never leak onto a read port
  always_comb begin
    data = store[addr];
    if (byp_hit)      data = wr_data;
    if (addr == '0)   data = '0;
  end

endmodule

module reg_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr_0,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  output logic [DATA_WIDTH-1:0] rd_data_0,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]  store;
  logic [DEPTH-1:1]                  wr_sel;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]                 byp_hit;

  assign rd_addr   = {rd_addr_1, rd_addr_0};
  assign rd_data_0 = rd_data[0];
  assign rd_data_1 = rd_data[1];

  // r0 has no flop; it is a constant zero word in the read array
  assign store[0] = '0;

  // one-hot write decode; index 0 has no enable so r0 writes vanish here
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < DEPTH; i++)
      wr_sel[i] = wr_en && (wr_addr == ADDR_WIDTH'(i));
  end

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_reg
      reg_file_2r1w_entry #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_entry (
        .clk (clk),
        .rst (rst),
        .en  (wr_sel[gi]),
        .d   (wr_data),
        .q   (store[gi])
      );
    end
  endgenerate

  // bypass match per read port; suppressed during reset since that write is dropped
  always_comb begin
    byp_hit = '0;
    for (int p = 0; p < NUM_RD; p++)
      byp_hit[p] = (BYPASS != 0) && wr_en && !rst && (wr_addr == rd_addr[p]);
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rport
      reg_file_2r1w_rport #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
      ) u_rport (
        .store   (store),
        .addr    (rd_addr[gi]),
        .byp_hit (byp_hit[gi]),
        .wr_data (wr_data),
        .data    (rd_data[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: drives a BYPASS=1 and a BYPASS=0 instance with the same
// stimulus; a driver pushes expected read data into a queue, a monitor pops
// and compares at the falling edge.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_0, rd_addr_1, wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd0_b, rd1_b, rd0_n, rd1_n;

  always #5 clk = ~clk;

  reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_data_0(rd0_b), .rd_data_1(rd1_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_data_0(rd0_n), .rd_data_1(rd1_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  typedef struct {
    int          id;
    logic [31:0] e0_b, e1_b, e0_n, e1_n;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [32];
  int          total = 0;
  int          bad   = 0;
  int          seq   = 0;
  bit          done  = 0;

  // reference read: r0 is zero, bypass only when enabled and not in reset
  function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wr_en && !rst && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  // apply one cycle of stimulus, optionally queue expectations, then retire the edge
  task automatic drive(input bit r, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a0,
                       input logic [4:0] a1, input bit chk);
    exp_t e;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_0 = a0; rd_addr_1 = a1;
    if (chk) begin
      e.id   = seq++;
      e.e0_b = model_rd(a0, 1'b1);
      e.e1_b = model_rd(a1, 1'b1);
      e.e0_n = model_rd(a0, 1'b0);
      e.e1_n = model_rd(a1, 1'b0);
      sb.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end else if (we && wa != 5'd0) begin
      mem[wa] = wd;
    end
    #1;
  endtask

  // monitor: outputs are combinational, so each cycle with a queued entry is a sample
  always @(negedge clk) begin
    exp_t e;
    if (!done && sb.size() > 0) begin
      e = sb.pop_front();
      total += 4;
      if (rd0_b !== e.e0_b) begin
        bad++;
        $display("FAIL byp_rd0 #%0d addr=%0d got=%h exp=%h", e.id, rd_addr_0, rd0_b, e.e0_b);
      end
      if (rd1_b !== e.e1_b) begin
        bad++;
        $display("FAIL byp_rd1 #%0d addr=%0d got=%h exp=%h", e.id, rd_addr_1, rd1_b, e.e1_b);
      end
      if (rd0_n !== e.e0_n) begin
        bad++;
        $display("FAIL nob_rd0 #%0d addr=%0d got=%h exp=%h", e.id, rd_addr_0, rd0_n, e.e0_n);
      end
      if (rd1_n !== e.e1_n) begin
        bad++;
        $display("FAIL nob_rd1 #%0d addr=%0d got=%h exp=%h", e.id, rd_addr_1, rd1_n, e.e1_n);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_0 = '0; rd_addr_1 = '0;
    @(posedge clk); #1;

    // initial reset: stored contents unknown beforehand, so nothing checked
    drive(1, 0, 0, 0, 0, 0, 0);

    // post-reset sweep of every index on both ports
    for (int a = 0; a < 32; a++) drive(0, 0, 0, 0, 5'(a), 5'(31 - a), 1);

    // write / readback
    drive(0, 1, 8,  32'hDEADBEEF, 0, 0, 1);
    drive(0, 1, 31, 32'h12345678, 8, 0, 1);
    drive(0, 0, 0,  0, 8, 31, 1);
    drive(0, 0, 0,  0, 9, 9, 1);

    // r0 write is ignored before, during and after the edge
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);

    // write-enable gating
    drive(0, 0, 5, 32'hA5A5A5A5, 5, 5, 1);
    drive(0, 0, 0, 0, 5, 5, 1);

    // same-cycle read-during-write: configs differ before the edge, agree after
    drive(0, 1, 3, 32'h11111111, 0, 0, 1);
    drive(0, 1, 3, 32'h22222222, 3, 3, 1);
    drive(0, 0, 0, 0, 3, 3, 1);

    // reset beats a same-edge write; no bypass while reset is high
    drive(0, 1, 4, 32'h0000CAFE, 0, 0, 1);
    drive(1, 1, 4, 32'hBEEF0000, 4, 4, 1);
    drive(0, 0, 0, 0, 4, 8, 1);

    // random traffic with occasional mid-sequence reset
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] wa, a0, a1;
      bit r;
      wa = 5'($urandom_range(0, 31));
      a0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r  = ($urandom_range(0, 99) == 0);
      drive(r, 1'($urandom_range(0, 1)), wa, $urandom, a0, a1, 1);
    end

    // drain: monitor must have consumed every queued expectation
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop so a broken run still terminates
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
